// File: rtl/cp0_timer_ext_pkg.sv
// Shared constants for the CP0 block: register numbers, field positions and exception codes.
package cp0_timer_ext_pkg;

    // CP0 register numbers
    localparam logic [4:0] AddrCount   = 5'd9;
    localparam logic [4:0] AddrCompare = 5'd11;
    localparam logic [4:0] AddrSr      = 5'd12;
    localparam logic [4:0] AddrCause   = 5'd13;
    localparam logic [4:0] AddrEpc     = 5'd14;
    localparam logic [4:0] AddrPrid    = 5'd15;

    // SR fields
    localparam int unsigned SrIeBit  = 0;
    localparam int unsigned SrExlBit = 1;
    localparam int unsigned ImLsb    = 8;
    localparam int unsigned ImMsb    = 15;

    // Cause fields
    localparam int unsigned IpLsb      = 8;
    localparam int unsigned IpMsb      = 15;
    localparam int unsigned CauseBdBit = 31;
    localparam int unsigned CauseTiBit = 30;
    localparam int unsigned ExcLsb     = 2;
    localparam int unsigned ExcMsb     = 6;

    // Exception codes
    localparam logic [4:0] ExcInt  = 5'd0;
    localparam logic [4:0] ExcAdel = 5'd4;
    localparam logic [4:0] ExcAdes = 5'd5;
    localparam logic [4:0] ExcRi   = 5'd10;
    localparam logic [4:0] ExcOv   = 5'd12;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a COUNT_DIV prescaler; raises TI when Count steps onto Compare.
module cp0_timer #(
    parameter int unsigned COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam logic [7:0] PrescMax = 8'(COUNT_DIV - 1);

    logic [7:0]  presc_q, presc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;
    logic        tick;
    logic [31:0] count_inc;

    // Next-state: prescaled increment, software loads override the tick, Compare write clears TI.
    always_comb begin
        tick      = (presc_q == PrescMax);
        count_inc = count_q + 32'd1;
        presc_d   = tick ? 8'd0 : presc_q + 8'd1;
        count_d   = tick ? count_inc : count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (tick && (count_inc == compare_q)) begin
            ti_d = 1'b1;
        end
        // A Count load never raises TI by itself.
        if (count_we) begin
            count_d = wdata;
            presc_d = 8'd0;
            ti_d    = ti_q;
        end
        if (compare_we) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end
    end

    // Timer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q   <= 8'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_timer_ext.sv
// MIPS CP0 for the M stage: SR, Cause, EPC, PRId, interrupt request logic and an optional timer.
module cp0_timer_ext
    import cp0_timer_ext_pkg::*;
#(
    parameter int unsigned HW_INT_N  = 6,
    parameter bit          TIMER_EN  = 1'b1,
    parameter int unsigned COUNT_DIV = 1,
    parameter logic [31:0] PRID      = 32'h0000_8000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [4:0]          addr,
    input  logic [31:0]         wdata,
    input  logic                bd_in,
    input  logic [31:0]         vpc,
    input  logic [4:0]          exc_code_in,
    input  logic [HW_INT_N-1:0] hw_int,
    input  logic                eret,
    output logic                req,
    output logic [31:0]         epc,
    output logic [31:0]         rdata,
    output logic                exl,
    output logic                timer_irq
);

    if (HW_INT_N < 1 || HW_INT_N > (TIMER_EN ? 5 : 6)) begin : gen_bad_hw_int_n
        $error("cp0_timer_ext: HW_INT_N out of range for this TIMER_EN setting");
    end
    if (COUNT_DIV < 1 || COUNT_DIV > 256) begin : gen_bad_count_div
        $error("cp0_timer_ext: COUNT_DIV must be 1..256");
    end

    logic        ie_q, ie_d;
    logic        exl_q, exl_d;
    logic [7:0]  im_q, im_d;
    logic        bd_q, bd_d;
    logic [4:0]  exc_q, exc_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [31:0] epc_q, epc_d;

    logic [31:0] count, compare;
    logic        ti;
    logic [5:0]  hw_ext;
    logic [7:0]  pend;
    logic        int_term;
    logic        count_we, compare_we;

    // Absent lines read as 0; IP[7] is shared between hw_int[5] and the timer.
    assign hw_ext   = 6'(hw_int);
    assign pend     = {hw_ext[5] | ti, hw_ext[4:0], ip_sw_q};
    assign int_term = ie_q & (|(pend & im_q));
    assign req      = ~exl_q & ~eret & ((exc_code_in != 5'd0) | int_term);

    // Taking an exception swallows any mtc0 in the same cycle, timer writes included.
    assign count_we   = we & ~req & (addr == AddrCount);
    assign compare_we = we & ~req & (addr == AddrCompare);

    if (TIMER_EN) begin : gen_timer
        cp0_timer #(
            .COUNT_DIV(COUNT_DIV)
        ) u_timer (
            .clk       (clk),
            .reset     (reset),
            .count_we  (count_we),
            .compare_we(compare_we),
            .wdata     (wdata),
            .count     (count),
            .compare   (compare),
            .ti        (ti)
        );
    end else begin : gen_no_timer
        assign count   = 32'd0;
        assign compare = 32'd0;
        assign ti      = 1'b0;
    end

    // Next-state for SR/Cause/EPC: exception entry beats mtc0, eret has the last word on EXL.
    always_comb begin
        ie_d    = ie_q;
        exl_d   = exl_q;
        im_d    = im_q;
        bd_d    = bd_q;
        exc_d   = exc_q;
        ip_sw_d = ip_sw_q;
        epc_d   = epc_q;
        ip_hw_d = pend[7:2];
        if (req) begin
            bd_d  = bd_in;
            epc_d = bd_in ? vpc - 32'd4 : vpc;
            exc_d = int_term ? ExcInt : exc_code_in;
            exl_d = 1'b1;
        end else if (we) begin
            case (addr)
                AddrSr: begin
                    im_d  = wdata[ImMsb:ImLsb];
                    exl_d = wdata[SrExlBit];
                    ie_d  = wdata[SrIeBit];
                end
                AddrCause: ip_sw_d = wdata[IpLsb+1:IpLsb];
                AddrEpc:   epc_d   = wdata;
                default: ;
            endcase
        end
        if (eret) begin
            exl_d = 1'b0;
        end
    end

    // CP0 register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q    <= 1'b0;
            exl_q   <= 1'b0;
            im_q    <= 8'd0;
            bd_q    <= 1'b0;
            exc_q   <= 5'd0;
            ip_sw_q <= 2'd0;
            ip_hw_q <= 6'd0;
            epc_q   <= 32'd0;
        end else begin
            ie_q    <= ie_d;
            exl_q   <= exl_d;
            im_q    <= im_d;
            bd_q    <= bd_d;
            exc_q   <= exc_d;
            ip_sw_q <= ip_sw_d;
            ip_hw_q <= ip_hw_d;
            epc_q   <= epc_d;
        end
    end

    // Combinational register read.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            AddrCount:   rdata = count;
            AddrCompare: rdata = compare;
            AddrSr: begin
                rdata[ImMsb:ImLsb] = im_q;
                rdata[SrExlBit]    = exl_q;
                rdata[SrIeBit]     = ie_q;
            end
            AddrCause: begin
                rdata[CauseBdBit]      = bd_q;
                rdata[CauseTiBit]      = ti;
                rdata[IpMsb:IpLsb+2]   = ip_hw_q;
                rdata[IpLsb+1:IpLsb]   = ip_sw_q;
                rdata[ExcMsb:ExcLsb]   = exc_q;
            end
            AddrEpc:  rdata = epc_q;
            AddrPrid: rdata = PRID;
            default: ;
        endcase
    end

    assign epc       = epc_q;
    assign exl       = exl_q;
    assign timer_irq = ti;

endmodule
